// File: rtl/dma_arbiter.sv
// Round-robin arbiter sharing one DMA byte-transfer engine between CHANNELS requesters.
// Define DMA_ARB_PRIO0_EN to give channel 0 absolute priority over the rotation.
module dma_arbiter #(
  parameter int CHANNELS = 4,
  parameter int AW       = 22,
  parameter int SW       = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CHANNELS-1:0]   ch_req,
  input  logic [CHANNELS*AW-1:0] ch_addr,
  input  logic [CHANNELS-1:0]   ch_rnw,
  input  logic [CHANNELS*8-1:0] ch_wd,
  output logic [CHANNELS-1:0]   ch_ack,
  output logic [CHANNELS-1:0]   ch_end,
  output logic [7:0]            ch_rd,
  output logic                  dma_req,
  output logic [AW-1:0]         dma_addr,
  output logic                  dma_rnw,
  output logic [7:0]            dma_wd,
  input  logic                  dma_ack,
  input  logic                  dma_end,
  input  logic [7:0]            dma_rd,
  input  logic                  dma_busynready,
  output logic [SW-1:0]         arb_owner,
  output logic                  arb_busy
);

  localparam int NSEL = 2**SW;

  logic [SW-1:0]   sel, fl, rr_next, cand;
  logic            pend, rr_found;
  logic [NSEL-1:0] req_ext, rnw_ext;
  logic [AW-1:0]   addr_a [NSEL];
  logic [7:0]      wd_a   [NSEL];

  // Channel views padded to the full index range so sel indexes them directly.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    req_ext = NSEL'(ch_req);
    rnw_ext = NSEL'(ch_rnw);
    addr_a  = '{default: '0};
    wd_a    = '{default: '0};
    for (int i = 0; i < CHANNELS; i++) begin
      addr_a[i] = ch_addr[i*AW +: AW];
      wd_a[i]   = ch_wd[i*8 +: 8];
    end
  end

  assign dma_req   = req_ext[sel];
  assign dma_addr  = addr_a[sel];
  assign dma_rnw   = rnw_ext[sel];
  assign dma_wd    = wd_a[sel];
  assign ch_rd     = dma_rd;
  assign arb_owner = sel;
  assign arb_busy  = pend;

  always_comb begin
    ch_ack = '0;
    ch_end = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      ch_ack[i] = dma_ack & (sel == SW'(i));
      ch_end[i] = dma_end & (fl == SW'(i));
    end
  end

  // Scan sel+1 .. sel (wrapping); the current owner is checked last.
  always_comb begin
    rr_found = 1'b0;
    rr_next  = sel;
    cand     = '0;
    for (int k = 1; k <= CHANNELS; k++) begin
      cand = SW'((int'(sel) + k) % CHANNELS);
      if (!rr_found && req_ext[cand]) begin
        rr_found = 1'b1;
        rr_next  = cand;
      end
    end
`ifdef DMA_ARB_PRIO0_EN
    if (ch_req[0]) begin
      rr_found = 1'b1;
      rr_next  = '0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel  <= '0;
      fl   <= '0;
      pend <= 1'b0;
    end else if (dma_ack) begin
      // NOTE: non-blocking, so fl captures the pre-edge sel while sel rotates at the same edge.
      fl   <= sel;
      pend <= 1'b1;
      if (rr_found) sel <= rr_next;
    end else begin
      if (dma_end) pend <= 1'b0;
      // Owner gave up while the engine is not holding a command: hand over now.
      if (!dma_busynready && !req_ext[sel] && rr_found) sel <= rr_next;
    end
  end

endmodule

// File: tb/tb_dma_arbiter.sv
// Table-driven bench for dma_arbiter (default build); ch_end/ch_rd checked through a scoreboard.
module tb_dma_arbiter;

  localparam int CH = 4;
  localparam int AW = 22;
  localparam int SW = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic [CH-1:0]   ch_req;
  logic [CH*AW-1:0] ch_addr;
  logic [CH-1:0]   ch_rnw;
  logic [CH*8-1:0] ch_wd;
  logic [CH-1:0]   ch_ack, ch_end;
  logic [7:0]      ch_rd;
  logic            dma_req, dma_rnw, dma_ack, dma_end, dma_busynready;
  logic [AW-1:0]   dma_addr;
  logic [7:0]      dma_wd, dma_rd;
  logic [SW-1:0]   arb_owner;
  logic            arb_busy;

  dma_arbiter #(.CHANNELS(CH), .AW(AW), .SW(SW)) dut (
    .clk(clk), .rst(rst),
    .ch_req(ch_req), .ch_addr(ch_addr), .ch_rnw(ch_rnw), .ch_wd(ch_wd),
    .ch_ack(ch_ack), .ch_end(ch_end), .ch_rd(ch_rd),
    .dma_req(dma_req), .dma_addr(dma_addr), .dma_rnw(dma_rnw), .dma_wd(dma_wd),
    .dma_ack(dma_ack), .dma_end(dma_end), .dma_rd(dma_rd),
    .dma_busynready(dma_busynready),
    .arb_owner(arb_owner), .arb_busy(arb_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       ack, en, bsy;
    logic [7:0] rd;
    int         owner;
    logic [3:0] xack, xend;
    logic       xbusy;
  } vec_t;

  vec_t vq[$];
  int   sb[$];
  int   checks = 0;
  int   failures = 0;

  logic [AW-1:0] addr_c [CH];
  logic [7:0]    wd_c   [CH];
  logic          rnw_c  [CH];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic r, input logic [3:0] req, input logic ack, input logic en,
                     input logic bsy, input logic [7:0] rd, input int owner,
                     input logic [3:0] xack, input logic [3:0] xend, input logic xbusy);
    vec_t v;
    v.rst = r; v.req = req; v.ack = ack; v.en = en; v.bsy = bsy; v.rd = rd;
    v.owner = owner; v.xack = xack; v.xend = xend; v.xbusy = xbusy;
    vq.push_back(v);
  endtask

  initial begin
    for (int i = 0; i < CH; i++) begin
      addr_c[i] = 22'h012345 + AW'(i) * 22'h001000;
      wd_c[i]   = 8'h50 + 8'(i);
      rnw_c[i]  = 1'b1;
    end
    wd_c[3]  = 8'hA5;
    rnw_c[3] = 1'b0;
    for (int i = 0; i < CH; i++) begin
      ch_addr[i*AW +: AW] = addr_c[i];
      ch_wd[i*8 +: 8]     = wd_c[i];
      ch_rnw[i]           = rnw_c[i];
    end

    //  rst req     ack en bsy rd     own xack     xend     busy
    // ch0 single read
    add(0, 4'b0001, 0, 0, 0, 8'h00, 0, 4'b0000, 4'b0000, 0);
    add(0, 4'b0001, 1, 0, 1, 8'h00, 0, 4'b0001, 4'b0000, 0);
    add(0, 4'b0000, 0, 1, 1, 8'h3C, 0, 4'b0000, 4'b0001, 1);
    add(0, 4'b0000, 0, 0, 0, 8'h00, 0, 4'b0000, 4'b0000, 0);
    // ch1/ch2 pipelined alternation
    add(0, 4'b0110, 0, 0, 0, 8'h00, 0, 4'b0000, 4'b0000, 0);
    add(0, 4'b0110, 0, 0, 1, 8'h00, 1, 4'b0000, 4'b0000, 0);
    add(0, 4'b0110, 1, 0, 1, 8'h00, 1, 4'b0010, 4'b0000, 0);
    add(0, 4'b0110, 0, 0, 1, 8'h00, 2, 4'b0000, 4'b0000, 1);
    add(0, 4'b0110, 1, 1, 1, 8'h11, 2, 4'b0100, 4'b0010, 1);
    add(0, 4'b0110, 0, 0, 1, 8'h00, 1, 4'b0000, 4'b0000, 1);
    add(0, 4'b0110, 1, 1, 1, 8'h22, 1, 4'b0010, 4'b0100, 1);
    add(0, 4'b0110, 0, 0, 1, 8'h00, 2, 4'b0000, 4'b0000, 1);
    add(0, 4'b0110, 1, 1, 1, 8'h33, 2, 4'b0100, 4'b0010, 1);
    add(0, 4'b0000, 0, 0, 1, 8'h00, 1, 4'b0000, 4'b0000, 1);
    add(0, 4'b0000, 0, 1, 1, 8'h44, 1, 4'b0000, 4'b0100, 1);
    add(0, 4'b0000, 0, 0, 0, 8'h00, 1, 4'b0000, 4'b0000, 0);
    // all four requesting, full rotation incl. ch3 write
    add(1, 4'b0000, 0, 0, 0, 8'h00, 1, 4'b0000, 4'b0000, 0);
    add(0, 4'b1111, 0, 0, 0, 8'h00, 0, 4'b0000, 4'b0000, 0);
    add(0, 4'b1111, 1, 0, 1, 8'h00, 0, 4'b0001, 4'b0000, 0);
    add(0, 4'b1111, 0, 0, 1, 8'h00, 1, 4'b0000, 4'b0000, 1);
    add(0, 4'b1111, 1, 1, 1, 8'h55, 1, 4'b0010, 4'b0001, 1);
    add(0, 4'b1111, 0, 0, 1, 8'h00, 2, 4'b0000, 4'b0000, 1);
    add(0, 4'b1111, 1, 1, 1, 8'h66, 2, 4'b0100, 4'b0010, 1);
    add(0, 4'b1111, 0, 0, 1, 8'h00, 3, 4'b0000, 4'b0000, 1);
    add(0, 4'b1111, 1, 1, 1, 8'h77, 3, 4'b1000, 4'b0100, 1);
    add(0, 4'b1111, 0, 0, 1, 8'h00, 0, 4'b0000, 4'b0000, 1);
    add(0, 4'b1111, 1, 1, 1, 8'h88, 0, 4'b0001, 4'b1000, 1);
    add(0, 4'b0000, 0, 0, 1, 8'h00, 1, 4'b0000, 4'b0000, 1);
    add(0, 4'b0000, 0, 1, 1, 8'h99, 1, 4'b0000, 4'b0001, 1);
    add(0, 4'b0000, 0, 0, 0, 8'h00, 1, 4'b0000, 4'b0000, 0);
    // ch2 drops req, ch0 waiting: idle reassign in the engine's second data cycle
    add(1, 4'b0000, 0, 0, 0, 8'h00, 1, 4'b0000, 4'b0000, 0);
    add(0, 4'b0100, 0, 0, 0, 8'h00, 0, 4'b0000, 4'b0000, 0);
    add(0, 4'b0100, 1, 0, 1, 8'h00, 2, 4'b0100, 4'b0000, 0);
    add(0, 4'b0001, 0, 0, 1, 8'h00, 2, 4'b0000, 4'b0000, 1);
    add(0, 4'b0001, 0, 1, 0, 8'hAB, 2, 4'b0000, 4'b0100, 1);
    add(0, 4'b0001, 0, 0, 0, 8'h00, 0, 4'b0000, 4'b0000, 0);
    add(0, 4'b0001, 1, 0, 1, 8'h00, 0, 4'b0001, 4'b0000, 0);
    add(0, 4'b0000, 0, 1, 1, 8'hCD, 0, 4'b0000, 4'b0001, 1);
    // ch1 ends in the same cycle ch3 is acked
    add(1, 4'b0000, 0, 0, 0, 8'h00, 0, 4'b0000, 4'b0000, 0);
    add(0, 4'b0010, 0, 0, 0, 8'h00, 0, 4'b0000, 4'b0000, 0);
    add(0, 4'b1010, 1, 0, 1, 8'h00, 1, 4'b0010, 4'b0000, 0);
    add(0, 4'b1000, 1, 1, 1, 8'hEF, 3, 4'b1000, 4'b0010, 1);
    add(0, 4'b0000, 0, 0, 1, 8'h00, 3, 4'b0000, 4'b0000, 1);
    add(0, 4'b0000, 0, 1, 1, 8'h12, 3, 4'b0000, 4'b1000, 1);
    add(0, 4'b0000, 0, 0, 0, 8'h00, 3, 4'b0000, 4'b0000, 0);
    // ch0/ch1 held: alternation, then reset while a transfer is in flight
    add(1, 4'b0000, 0, 0, 0, 8'h00, 3, 4'b0000, 4'b0000, 0);
    add(0, 4'b0011, 1, 0, 1, 8'h00, 0, 4'b0001, 4'b0000, 0);
    add(0, 4'b0011, 1, 1, 1, 8'h21, 1, 4'b0010, 4'b0001, 1);
    add(0, 4'b0011, 1, 1, 1, 8'h32, 0, 4'b0001, 4'b0010, 1);
    add(0, 4'b0011, 1, 1, 1, 8'h43, 1, 4'b0010, 4'b0001, 1);
    add(1, 4'b0000, 0, 0, 1, 8'h00, 0, 4'b0000, 4'b0000, 1);
    add(0, 4'b0000, 0, 0, 0, 8'h00, 0, 4'b0000, 4'b0000, 0);

    rst = 1'b1; ch_req = '0; dma_ack = 1'b0; dma_end = 1'b0;
    dma_busynready = 1'b0; dma_rd = '0;
    repeat (2) @(posedge clk);

    for (int n = 0; n < vq.size(); n++) begin
      vec_t v;
      v = vq[n];
      @(negedge clk);
      rst = v.rst; ch_req = v.req; dma_ack = v.ack; dma_end = v.en;
      dma_busynready = v.bsy; dma_rd = v.rd;
      #1;
      check($sformatf("owner[%0d]", n), 32'(arb_owner), 32'(v.owner));
      check($sformatf("dma_req[%0d]", n), 32'(dma_req), 32'(v.req[v.owner]));
      check($sformatf("dma_addr[%0d]", n), 32'(dma_addr), 32'(addr_c[v.owner]));
      check($sformatf("dma_rnw[%0d]", n), 32'(dma_rnw), 32'(rnw_c[v.owner]));
      check($sformatf("dma_wd[%0d]", n), 32'(dma_wd), 32'(wd_c[v.owner]));
      check($sformatf("ch_ack[%0d]", n), 32'(ch_ack), 32'(v.xack));
      check($sformatf("ch_end[%0d]", n), 32'(ch_end), 32'(v.xend));
      check($sformatf("arb_busy[%0d]", n), 32'(arb_busy), 32'(v.xbusy));
      if (ch_end != '0) begin
        if (sb.size() == 0) begin
          check($sformatf("sb_unexpected_end[%0d]", n), 32'(ch_end), 32'h0);
        end else begin
          int exp_ch;
          exp_ch = sb.pop_front();
          check($sformatf("sb_end_ch[%0d]", n), 32'(ch_end), 32'(4'b0001 << exp_ch));
          check($sformatf("sb_rd[%0d]", n), 32'(ch_rd), 32'(v.rd));
        end
      end
      if (v.ack) sb.push_back(v.owner);
      if (v.rst) sb.delete();
    end

    @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
